// File: rtl/param_div_unit.sv
// Multi-cycle radix-2 non-restoring divider for DIV/DIVU/REM/REMU with zero-divide and overflow bypass.
// Optional last-result cache enabled by defining DIV_RESULT_CACHE_EN.
module param_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clk_en_i,
  input  logic             kill_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [1:0]       operation_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_divide_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, CORRECT, DONE} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [1:0]       op_q;
  logic             dvd_neg_q, quo_neg_q, zd_q;
  logic [WIDTH-1:0] div_q, quo_q, res_q;
  logic [WIDTH+1:0] rem_q;

  logic             is_signed, is_rem, dvd_neg, dsr_neg, div_zero, sgn_ovf, cache_hit;
  logic [WIDTH-1:0] dvd_mag, dsr_mag, accept_res, cache_res;
  logic [WIDTH+1:0] shifted, rem_next;
  logic [WIDTH-1:0] rem_mag, q_final, r_final, correct_res;

  assign is_signed = ~operation_i[0];
  assign is_rem    = operation_i[1];
  assign dvd_neg   = is_signed & dividend_i[WIDTH-1];
  assign dsr_neg   = is_signed & divisor_i[WIDTH-1];
  assign dvd_mag   = dvd_neg ? -dividend_i : dividend_i;
  assign dsr_mag   = dsr_neg ? -divisor_i : divisor_i;
  assign div_zero  = (divisor_i == '0);
  assign sgn_ovf   = is_signed && (dividend_i == MOST_NEG) && (&divisor_i);

  // One non-restoring step: add when the partial remainder is negative, subtract otherwise.
  assign shifted  = {rem_q[WIDTH:0], quo_q[WIDTH-1]};
  assign rem_next = rem_q[WIDTH+1] ? shifted + {2'b00, div_q} : shifted - {2'b00, div_q};

  assign rem_mag     = rem_q[WIDTH+1] ? rem_q[WIDTH-1:0] + div_q : rem_q[WIDTH-1:0];
  assign q_final     = quo_neg_q ? -quo_q : quo_q;
  assign r_final     = dvd_neg_q ? -rem_mag : rem_mag;
  assign correct_res = op_q[1] ? r_final : q_final;

`ifdef DIV_RESULT_CACHE_EN
  logic             cache_vld_q, cache_sgn_q;
  logic [WIDTH-1:0] cache_dvd_q, cache_dsr_q, cache_quo_q, cache_rem_q;
  logic [WIDTH-1:0] req_dvd_q, req_dsr_q;

  assign cache_hit = cache_vld_q && (cache_sgn_q == is_signed) &&
                     (cache_dvd_q == dividend_i) && (cache_dsr_q == divisor_i);
  assign cache_res = is_rem ? cache_rem_q : cache_quo_q;

  // Only results that finished the iterative path are remembered; any kill drops the entry.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cache_vld_q <= 1'b0;
      cache_sgn_q <= 1'b0;
      cache_dvd_q <= '0;
      cache_dsr_q <= '0;
      cache_quo_q <= '0;
      cache_rem_q <= '0;
      req_dvd_q   <= '0;
      req_dsr_q   <= '0;
    end else if (clk_en_i) begin
      if (kill_i) begin
        cache_vld_q <= 1'b0;
      end else begin
        if (state_q == IDLE && valid_i) begin
          req_dvd_q <= dividend_i;
          req_dsr_q <= divisor_i;
        end
        if (state_q == CORRECT) begin
          cache_vld_q <= 1'b1;
          cache_sgn_q <= ~op_q[0];
          cache_dvd_q <= req_dvd_q;
          cache_dsr_q <= req_dsr_q;
          cache_quo_q <= q_final;
          cache_rem_q <= r_final;
        end
      end
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = '0;
`endif

  always_comb begin
    accept_res = cache_res;
    if (div_zero)     accept_res = is_rem ? dividend_i : '1;
    else if (sgn_ovf) accept_res = is_rem ? '0 : MOST_NEG;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)      state_q <= IDLE;
    else if (clk_en_i) state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i) state_d = (div_zero || sgn_ovf || cache_hit) ? DONE : DIVIDE;
      DIVIDE:  if (cnt_q == CW'(WIDTH-1)) state_d = CORRECT;
      CORRECT: state_d = DONE;
      DONE:    if (ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill_i) state_d = IDLE;
  end

  always_comb begin
    ready_o       = (state_q == IDLE);
    valid_o       = (state_q == DONE);
    result_o      = (state_q == DONE) ? res_q : '0;
    zero_divide_o = (state_q == DONE) & zd_q;
  end

  // Operands are held as magnitudes; signs are reapplied in CORRECT.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      op_q      <= '0;
      dvd_neg_q <= 1'b0;
      quo_neg_q <= 1'b0;
      zd_q      <= 1'b0;
      div_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      res_q     <= '0;
    end else if (clk_en_i) begin
      if (kill_i) begin
        cnt_q <= '0;
      end else begin
        case (state_q)
          IDLE: if (valid_i) begin
            op_q      <= operation_i;
            dvd_neg_q <= dvd_neg;
            quo_neg_q <= dvd_neg ^ dsr_neg;
            zd_q      <= div_zero;
            div_q     <= dsr_mag;
            quo_q     <= dvd_mag;
            rem_q     <= '0;
            cnt_q     <= '0;
            res_q     <= accept_res;
          end
          DIVIDE: begin
            rem_q <= rem_next;
            quo_q <= {quo_q[WIDTH-2:0], ~rem_next[WIDTH+1]};
            cnt_q <= (cnt_q == CW'(WIDTH-1)) ? '0 : cnt_q + 1'b1;
          end
          CORRECT: res_q <= correct_res;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_param_div_unit.sv
// Directed testbench for param_div_unit at WIDTH=32; latency expectations follow DIV_RESULT_CACHE_EN.
module tb_param_div_unit;

  localparam int W = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;
`ifdef DIV_RESULT_CACHE_EN
  localparam int HIT_LAT = 1;
`else
  localparam int HIT_LAT = 34;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clk_en = 1'b1;
  logic         kill = 1'b0;
  logic         valid_in = 1'b0;
  logic         ready_out;
  logic [1:0]   operation = 2'b00;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         valid_out;
  logic         ready_in = 1'b0;
  logic [W-1:0] result;
  logic         zero_divide;

  int vec_cnt = 0;
  int err_cnt = 0;

  param_div_unit #(.WIDTH(W)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .kill_i(kill),
    .valid_i(valid_in), .ready_o(ready_out), .operation_i(operation),
    .dividend_i(dividend), .divisor_i(divisor), .valid_o(valid_out),
    .ready_i(ready_in), .result_o(result), .zero_divide_o(zero_divide)
  );

  always #5 clk = ~clk;

  // Issues one request and waits (bounded) for valid_o; edges counts enabled edges from acceptance.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic zd, output int edges);
    @(negedge clk);
    valid_in = 1'b1; operation = op; dividend = a; divisor = b;
    @(posedge clk);
    edges = 1;
    #1 valid_in = 1'b0;
    while (valid_out !== 1'b1 && edges < 100) begin
      @(posedge clk);
      if (clk_en) edges++;
      #1;
    end
    res = result;
    zd  = zero_divide;
  endtask

  task automatic consume();
    @(negedge clk);
    ready_in = 1'b1;
    @(posedge clk);
    #1 ready_in = 1'b0;
  endtask

  task automatic test_reset();
    valid_in = 1'b1; operation = OP_DIVU; dividend = 32'd1; divisor = 32'd1;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (ready_out !== 1'b1) begin err_cnt++; $display("[TB] FAIL reset_ready: got %b want 1", ready_out); end
    vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_valid: got %b want 0", valid_out); end
    vec_cnt++; if (result !== '0) begin err_cnt++; $display("[TB] FAIL reset_result: got %h want 0", result); end
    vec_cnt++; if (zero_divide !== 1'b0) begin err_cnt++; $display("[TB] FAIL reset_zd: got %b want 0", zero_divide); end
    valid_in = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    vec_cnt++; if (ready_out !== 1'b1) begin err_cnt++; $display("[TB] FAIL post_reset_ready: got %b want 1", ready_out); end
  endtask

  task automatic test_arith();
    logic [1:0]   ops  [10] = '{OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIVU, OP_REMU};
    logic [W-1:0] as   [10] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'hFFFFFFF8, 32'hFFFFFFF8,
                                32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [W-1:0] bs   [10] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'hFFFFFFFD,
                                32'd1, 32'h10, 32'd3, 32'd3};
    logic [W-1:0] exps [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd2, 32'hFFFFFFFE,
                                32'hFFFFFFFF, 32'hF, 32'h2AAAAAAA, 32'd2};
    int           lats [10] = '{34, HIT_LAT, 34, HIT_LAT, 34, HIT_LAT, 34, 34, 34, HIT_LAT};
    logic [W-1:0] res;
    logic         zd;
    int           edges;
    for (int i = 0; i < 10; i++) begin
      run_op(ops[i], as[i], bs[i], res, zd, edges);
      vec_cnt++; if (res !== exps[i]) begin err_cnt++; $display("[TB] FAIL arith_result[%0d]: got %h want %h", i, res, exps[i]); end
      vec_cnt++; if (edges != lats[i]) begin err_cnt++; $display("[TB] FAIL arith_latency[%0d]: got %0d want %0d", i, edges, lats[i]); end
      vec_cnt++; if (zd !== 1'b0) begin err_cnt++; $display("[TB] FAIL arith_zd[%0d]: got %b want 0", i, zd); end
      consume();
    end
  endtask

  task automatic test_special();
    logic [1:0]   ops  [6] = '{OP_DIVU, OP_REMU, OP_DIV, OP_REM, OP_DIV, OP_REM};
    logic [W-1:0] as   [6] = '{32'h12345678, 32'h12345678, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h80000000, 32'h80000000};
    logic [W-1:0] bs   [6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [W-1:0] exps [6] = '{32'hFFFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'h80000000, 32'd0};
    logic         zds  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [W-1:0] res;
    logic         zd;
    int           edges;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], res, zd, edges);
      vec_cnt++; if (res !== exps[i]) begin err_cnt++; $display("[TB] FAIL special_result[%0d]: got %h want %h", i, res, exps[i]); end
      vec_cnt++; if (edges != 1) begin err_cnt++; $display("[TB] FAIL special_latency[%0d]: got %0d want 1", i, edges); end
      vec_cnt++; if (zd !== zds[i]) begin err_cnt++; $display("[TB] FAIL special_zd[%0d]: got %b want %b", i, zd, zds[i]); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] res;
    logic         zd;
    int           edges;
    run_op(OP_DIVU, 32'd100, 32'd7, res, zd, edges);
    vec_cnt++; if (res !== 32'd14) begin err_cnt++; $display("[TB] FAIL bp_result: got %h want %h", res, 32'd14); end
    vec_cnt++; if (edges != 34) begin err_cnt++; $display("[TB] FAIL bp_latency: got %0d want 34", edges); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vec_cnt++; if (valid_out !== 1'b1) begin err_cnt++; $display("[TB] FAIL bp_hold_valid[%0d]: got %b want 1", i, valid_out); end
      vec_cnt++; if (result !== 32'd14) begin err_cnt++; $display("[TB] FAIL bp_hold_result[%0d]: got %h want %h", i, result, 32'd14); end
      vec_cnt++; if (ready_out !== 1'b0) begin err_cnt++; $display("[TB] FAIL bp_hold_ready[%0d]: got %b want 0", i, ready_out); end
    end
    consume();
    vec_cnt++; if (ready_out !== 1'b1) begin err_cnt++; $display("[TB] FAIL bp_release_ready: got %b want 1", ready_out); end
    vec_cnt++; if (valid_out !== 1'b0) begin err_cnt++; $display("[TB] FAIL bp_release_valid: got %b want 0", valid_out); end
    vec_cnt++; if (result !== '0) begin err_cnt++; $display("[TB] FAIL bp_release_result: got %h want 0", result); end
  endtask

  task automatic test_clock_enable();
    int edges;
    @(negedge clk);
    valid_in = 1'b1; operation = OP_DIVU; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clk);
    edges = 1;
    #1 valid_in = 1'b0; clk_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    vec_cnt++; if (ready_out !== 1'b0 || valid_out !== 1'b0) begin err_cnt++; $display("[TB] FAIL ce_stall: got ready=%b valid=%b want 0/0", ready_out, valid_out); end
    clk_en = 1'b1;
    while (valid_out !== 1'b1 && edges < 100) begin
      @(posedge clk);
      edges++;
      #1;
    end
    vec_cnt++; if (edges != 34) begin err_cnt++; $display("[TB] FAIL ce_latency: got %0d want 34", edges); end
    vec_cnt++; if (result !== 32'd100) begin err_cnt++; $display("[TB] FAIL ce_result: got %h want %h", result, 32'd100); end
    @(negedge clk);
    clk_en = 1'b0; ready_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (valid_out !== 1'b1 || result !== 32'd100) begin err_cnt++; $display("[TB] FAIL ce_done_hold: got valid=%b result=%h want 1/%h", valid_out, result, 32'd100); end
    @(negedge clk);
    clk_en = 1'b1;
    @(posedge clk);
    #1 ready_in = 1'b0;
    vec_cnt++; if (ready_out !== 1'b1) begin err_cnt++; $display("[TB] FAIL ce_release_ready: got %b want 1", ready_out); end
  endtask

  task automatic test_kill();
    logic [W-1:0] res;
    logic         zd;
    int           edges;
    int           seen;
    @(negedge clk);
    valid_in = 1'b1; operation = OP_DIVU; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (9) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk);
    #1 kill = 1'b0;
    vec_cnt++; if (ready_out !== 1'b1) begin err_cnt++; $display("[TB] FAIL kill_ready: got %b want 1", ready_out); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid_out !== 1'b0) seen++;
    end
    vec_cnt++; if (seen != 0) begin err_cnt++; $display("[TB] FAIL kill_no_result: got %0d valid cycles want 0", seen); end
    @(negedge clk);
    valid_in = 1'b1; kill = 1'b1; operation = OP_DIVU; dividend = 32'd5; divisor = 32'd0;
    @(posedge clk);
    #1 valid_in = 1'b0; kill = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++; if (valid_out !== 1'b0 || ready_out !== 1'b1) begin err_cnt++; $display("[TB] FAIL kill_vs_accept: got valid=%b ready=%b want 0/1", valid_out, ready_out); end
    run_op(OP_DIVU, 32'd9, 32'd3, res, zd, edges);
    vec_cnt++; if (res !== 32'd3) begin err_cnt++; $display("[TB] FAIL kill_next_result: got %h want 3", res); end
    vec_cnt++; if (edges != 34) begin err_cnt++; $display("[TB] FAIL kill_next_latency: got %0d want 34", edges); end
    consume();
    run_op(OP_DIVU, 32'd1000, 32'd10, res, zd, edges);
    vec_cnt++; if (res !== 32'd100) begin err_cnt++; $display("[TB] FAIL kill_flush_result: got %h want %h", res, 32'd100); end
    vec_cnt++; if (edges != 34) begin err_cnt++; $display("[TB] FAIL kill_flush_latency: got %0d want 34", edges); end
    consume();
  endtask

  task automatic test_cache();
    logic [W-1:0] res;
    logic         zd;
    int           edges;
    run_op(OP_DIV, 32'd100, 32'd7, res, zd, edges);
    vec_cnt++; if (res !== 32'd14) begin err_cnt++; $display("[TB] FAIL cache_div_result: got %h want %h", res, 32'd14); end
    vec_cnt++; if (edges != 34) begin err_cnt++; $display("[TB] FAIL cache_div_latency: got %0d want 34", edges); end
    consume();
    run_op(OP_REM, 32'd100, 32'd7, res, zd, edges);
    vec_cnt++; if (res !== 32'd2) begin err_cnt++; $display("[TB] FAIL cache_rem_result: got %h want 2", res); end
    vec_cnt++; if (edges != HIT_LAT) begin err_cnt++; $display("[TB] FAIL cache_rem_latency: got %0d want %0d", edges, HIT_LAT); end
    consume();
  endtask

  task automatic test_reset_mid_op();
    logic [W-1:0] res;
    logic         zd;
    int           edges;
    run_op(OP_DIVU, 32'd9, 32'd3, res, zd, edges);
    vec_cnt++; if (res !== 32'd3) begin err_cnt++; $display("[TB] FAIL rst_pre_result: got %h want 3", res); end
    consume();
    @(negedge clk);
    valid_in = 1'b1; operation = OP_DIVU; dividend = 32'd77; divisor = 32'd5;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec_cnt++; if (ready_out !== 1'b1 || valid_out !== 1'b0 || result !== '0) begin err_cnt++; $display("[TB] FAIL rst_mid_abort: got ready=%b valid=%b result=%h want 1/0/0", ready_out, valid_out, result); end
    @(posedge clk);
    #2 rst_n = 1'b1;
    run_op(OP_DIVU, 32'd9, 32'd3, res, zd, edges);
    vec_cnt++; if (res !== 32'd3) begin err_cnt++; $display("[TB] FAIL rst_post_result: got %h want 3", res); end
    vec_cnt++; if (edges != 34) begin err_cnt++; $display("[TB] FAIL rst_post_latency: got %0d want 34", edges); end
    consume();
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_backpressure();
    test_clock_enable();
    test_kill();
    test_cache();
    test_reset_mid_op();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/param_div_unit.md
PARAM_DIV_UNIT -- requirements
Module: param_div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand/result width, SHALL be an even value >= 8.
REQ-002 Port clk_i  in  1  rising-edge clock, the only clock.
REQ-003 Port rst_n_i  in  1  asynchronous reset, active-low.
REQ-004 Port clk_en_i  in  1  clock enable; when low, all state SHALL hold.
REQ-005 Port kill_i  in  1  synchronous flush of any in-flight operation.
REQ-006 Port valid_i  in  1  request valid.
REQ-007 Port ready_o  out  1  unit can accept a request.
REQ-008 Port operation_i  in  2  00=DIV, 01=DIVU, 10=REM, 11=REMU.
REQ-009 Port dividend_i  in  WIDTH  dividend.
REQ-010 Port divisor_i  in  WIDTH  divisor.
REQ-011 Port valid_o  out  1  result valid.
REQ-012 Port ready_i  in  1  consumer accepts the result.
REQ-013 Port result_o  out  WIDTH  quotient or remainder.
REQ-014 Port zero_divide_o  out  1  the current result came from a zero divisor; valid only with valid_o.

Function
REQ-015 FSM states SHALL be IDLE, DIVIDE, CORRECT and DONE; ready_o SHALL be 1 only in IDLE; valid_o SHALL be 1 only in DONE.
REQ-016 A request SHALL be accepted on an edge where clk_en_i=1, valid_i=1 and ready_o=1; operands and operation SHALL be captured on that edge.
REQ-017 Normal path: accept goes to DIVIDE; DIVIDE runs exactly WIDTH radix-2 non-restoring iterations, counted by a $clog2(WIDTH)-bit counter; CORRECT applies the remainder restore and sign fix; then DONE.
REQ-018 Normal-path valid_o SHALL rise after WIDTH+2 enabled edges, counting the acceptance edge as edge 1.
REQ-019 Signed ops SHALL divide magnitudes internally; the quotient is negated when operand signs differ; the remainder takes the dividend's sign.
REQ-020 Divisor 0 SHALL bypass iteration (accept -> DONE, valid_o after 1 edge): quotient all-ones, remainder = dividend, zero_divide_o=1.
REQ-021 Signed overflow (dividend = most-negative, divisor = -1) SHALL bypass (accept -> DONE): DIV returns most-negative, REM returns 0.
REQ-022 In DONE, result_o and zero_divide_o SHALL hold stable until an edge with ready_i=1; that edge SHALL move the FSM to IDLE.
REQ-023 kill_i=1 on an enabled edge SHALL force IDLE from any state; no result is produced; kill_i SHALL win over a simultaneous accept.
REQ-024 result_o SHALL be 0 whenever valid_o=0.

Reset
REQ-025 While rst_n_i=0: state IDLE, counter 0, operand/partial registers 0, result_o=0, valid_o=0, zero_divide_o=0, ready_o=1.
REQ-026 Reset asserted mid-operation SHALL abort immediately with no result; the first accept is possible on the first enabled edge after deassertion.

Configuration
REQ-027 Macro DIV_RESULT_CACHE_EN: when defined, the unit SHALL keep the last completed normal-path dividend, divisor, signedness, quotient and remainder.
REQ-028 With DIV_RESULT_CACHE_EN, a request matching the cached dividend, divisor and signedness (DIV/REM signed, DIVU/REMU unsigned) SHALL go accept -> DONE, with valid_o after 1 edge.
REQ-029 The cache SHALL be invalidated by reset and by kill_i; a killed operation SHALL never fill it.
REQ-030 Without DIV_RESULT_CACHE_EN, no cache storage SHALL exist and every non-special request SHALL take the REQ-018 latency.

Verification
REQ-031 WIDTH=32, DIV -7/2 -> 0xFFFFFFFD with valid_o on edge 34; REM -7/2 -> 0xFFFFFFFF.
REQ-032 DIVU 0x12345678/0 -> 0xFFFFFFFF, zero_divide_o=1, valid_o after 1 edge; REMU -> 0x12345678.
REQ-033 DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0; both 1-edge latency.
REQ-034 DIVU 100/7 with ready_i held low 5 cycles -> result_o stays 14 and valid_o stays 1 throughout; ready_o rises the cycle after ready_i=1.
REQ-035 kill_i pulsed during DIVIDE iteration 10 -> valid_o never rises, ready_o=1 next cycle; a subsequent DIVU 9/3 -> 3 at full latency.
REQ-036 DIV 100/7 then REM 100/7 -> 14 then 2; second op latency is 1 edge with DIV_RESULT_CACHE_EN, 34 edges without.
